// File: rtl/branch_resolve_pkg.sv
// Shared types and helpers for branch resolution: the prediction record and
// the correctness check applied when EX resolves the oldest jump/branch.
package branch_resolve_pkg;

    // Instruction address bus width and sequential fetch increment.
    localparam int unsigned INST_ADDR_W = 32;
    localparam logic [INST_ADDR_W-1:0] INST_ADDR_INC = 32'h4;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic                   taken;
        logic [INST_ADDR_W-1:0] addr;
    } pred_rec_t;

    function automatic logic is_mispredict(
        input pred_rec_t              head,
        input logic                   res_taken,
        input logic [INST_ADDR_W-1:0] res_target
    );
        return (head.taken != res_taken) || (res_taken && (head.addr != res_target));
    endfunction

    function automatic logic [INST_ADDR_W-1:0] correct_next_pc(
        input pred_rec_t              head,
        input logic                   res_taken,
        input logic [INST_ADDR_W-1:0] res_target
    );
        return res_taken ? res_target : (head.pc + INST_ADDR_INC);
    endfunction

endpackage

// File: rtl/branch_resolve_fifo.sv
// In-order prediction record queue with synchronous clear. A push into a full
// queue is accepted only when a pop happens on the same edge.
module branch_resolve_fifo
    import branch_resolve_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      push,
    input  logic      pop,
    input  pred_rec_t wdata,
    output pred_rec_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    pred_rec_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;
    logic             push_en;
    logic             pop_en;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == FULL_CNT);
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
        rdata   = mem[rd_ptr_q];
        cnt_d   = cnt_q;
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_en && !clr && !rst) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Compares IF-stage branch predictions against EX-stage outcomes, issues a
// one-cycle flush with the corrected PC on mispredict, then drains the pipe.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid_i,
    input  logic                   pred_taken_i,
    input  logic [INST_ADDR_W-1:0] pred_pc_i,
    input  logic [INST_ADDR_W-1:0] pred_addr_i,
    output logic                   pred_ready_o,
    input  logic                   res_valid_i,
    input  logic                   res_taken_i,
    input  logic [INST_ADDR_W-1:0] res_target_i,
    output logic                   flush_o,
    output logic [INST_ADDR_W-1:0] redirect_addr_o,
    output logic                   busy_o,
    output logic [31:0]            branch_cnt_o,
    output logic [31:0]            mispred_cnt_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    localparam int unsigned    CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic                   state_q, state_d;
    logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic                   flush_q;
    logic [INST_ADDR_W-1:0] redirect_q;
    logic [31:0]            branch_cnt_q;
    logic [31:0]            mispred_cnt_q;
    logic                   ovf_q;
    logic                   unf_q;

    pred_rec_t              wr_rec;
    pred_rec_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   idle;
    logic                   do_push;
    logic                   do_pop;
    logic                   mispredict;
    logic                   ovf_event;
    logic                   unf_event;
    logic [INST_ADDR_W-1:0] next_pc;

    always_comb begin
        idle       = (state_q == ST_IDLE);
        wr_rec     = '{pc: pred_pc_i, taken: pred_taken_i, addr: pred_addr_i};
        do_pop     = idle & res_valid_i & ~fifo_empty;
        do_push    = idle & pred_valid_i & (~fifo_full | do_pop);
        ovf_event  = idle & pred_valid_i & fifo_full & ~do_pop;
        unf_event  = idle & res_valid_i & fifo_empty;
        mispredict = do_pop & is_mispredict(head, res_taken_i, res_target_i);
        next_pc    = correct_next_pc(head, res_taken_i, res_target_i);
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            flush_q     <= mispredict;
            if (mispredict) begin
                redirect_q    <= next_pc;
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
            if (do_pop) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (ovf_event) begin
                ovf_q <= 1'b1;
            end
            if (unf_event) begin
                unf_q <= 1'b1;
            end
        end
    end

    // A mispredict discards every in-flight record, including a same-edge push.
    branch_resolve_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (mispredict),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (wr_rec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pred_ready_o    = idle & ~fifo_full;
    assign flush_o         = flush_q;
    assign redirect_addr_o = redirect_q;
    assign busy_o          = (state_q == ST_DRAIN);
    assign branch_cnt_o    = branch_cnt_q;
    assign mispred_cnt_o   = mispred_cnt_q;
    assign ovf_o           = ovf_q;
    assign unf_o           = unf_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a reference queue predicts each resolve
// outcome, which is queued and checked once the DUT's flush stage appears.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid_i;
    logic        pred_taken_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_addr_i;
    logic        pred_ready_o;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        flush_o;
    logic [31:0] redirect_addr_o;
    logic        busy_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;
    logic        ovf_o;
    logic        unf_o;

    typedef struct {
        logic        flush;
        logic [31:0] redir;
    } exp_t;

    pred_rec_t   mq[$];
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_bcnt = 0;
    logic [31:0] m_mcnt = 0;
    logic [31:0] m_redir = 0;

    always #5 clk = ~clk;

    branch_resolve #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_valid_i    (pred_valid_i),
        .pred_taken_i    (pred_taken_i),
        .pred_pc_i       (pred_pc_i),
        .pred_addr_i     (pred_addr_i),
        .pred_ready_o    (pred_ready_o),
        .res_valid_i     (res_valid_i),
        .res_taken_i     (res_taken_i),
        .res_target_i    (res_target_i),
        .flush_o         (flush_o),
        .redirect_addr_o (redirect_addr_o),
        .busy_o          (busy_o),
        .branch_cnt_o    (branch_cnt_o),
        .mispred_cnt_o   (mispred_cnt_o),
        .ovf_o           (ovf_o),
        .unf_o           (unf_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid_i = 1'b0;
        pred_taken_i = 1'b0;
        pred_pc_i    = '0;
        pred_addr_i  = '0;
        res_valid_i  = 1'b0;
        res_taken_i  = 1'b0;
        res_target_i = '0;
    endtask

    task automatic drive_pred(input logic [31:0] pc, input logic tk, input logic [31:0] addr);
        pred_valid_i = 1'b1;
        pred_pc_i    = pc;
        pred_taken_i = tk;
        pred_addr_i  = addr;
    endtask

    // Plain push while IDLE and not full; model follows the DUT queue.
    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] addr);
        drive_pred(pc, tk, addr);
        mq.push_back('{pc: pc, taken: tk, addr: addr});
        tick();
        idle_inputs();
    endtask

    // Resolve the oldest entry, optionally with a same-cycle push, and check
    // the registered flush/redirect and the counters one edge later.
    task automatic resolve(input logic tk, input logic [31:0] tgt, input logic with_push,
                           input logic [31:0] ppc, input logic ptk, input logic [31:0] paddr);
        exp_t      e;
        pred_rec_t h;
        logic      mis;
        if (mq.size() == 0) begin
            e = '{flush: 1'b0, redir: m_redir};
            if (with_push) mq.push_back('{pc: ppc, taken: ptk, addr: paddr});
        end else begin
            h   = mq.pop_front();
            mis = (h.taken != tk) || (tk && (h.addr != tgt));
            m_bcnt++;
            if (mis) begin
                m_mcnt++;
                m_redir = tk ? tgt : h.pc + 32'd4;
                mq.delete();
            end else if (with_push) begin
                mq.push_back('{pc: ppc, taken: ptk, addr: paddr});
            end
            e = '{flush: mis, redir: m_redir};
        end
        sb.push_back(e);
        if (with_push) drive_pred(ppc, ptk, paddr);
        res_valid_i  = 1'b1;
        res_taken_i  = tk;
        res_target_i = tgt;
        tick();
        idle_inputs();
        e = sb.pop_front();
        check("flush", {31'b0, flush_o}, {31'b0, e.flush});
        check("redirect", redirect_addr_o, e.redir);
        check("branch_cnt", branch_cnt_o, m_bcnt);
        check("mispred_cnt", mispred_cnt_o, m_mcnt);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'b0, pred_ready_o}, 32'd1);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_flush", {31'b0, flush_o}, 32'd0);
        check("rst_redirect", redirect_addr_o, 32'd0);
        check("rst_bcnt", branch_cnt_o, 32'd0);
        check("rst_ovf", {31'b0, ovf_o}, 32'd0);
        check("rst_unf", {31'b0, unf_o}, 32'd0);

        // Resolve on an empty queue.
        resolve(1'b1, 32'h1234, 1'b0, 0, 0, 0);
        check("unf_set", {31'b0, unf_o}, 32'd1);
        check("unf_busy", {31'b0, busy_o}, 32'd0);

        // Correct taken prediction.
        push(32'h100, 1'b1, 32'h80);
        resolve(1'b1, 32'h80, 1'b0, 0, 0, 0);
        check("ok_busy", {31'b0, busy_o}, 32'd0);

        // Predicted not taken, actually taken: flush then two drain cycles.
        push(32'h200, 1'b0, 32'h0);
        resolve(1'b1, 32'h300, 1'b0, 0, 0, 0);
        check("mis1_busy0", {31'b0, busy_o}, 32'd1);
        tick();
        check("mis1_flush_off", {31'b0, flush_o}, 32'd0);
        check("mis1_redir_hold", redirect_addr_o, 32'h300);
        check("mis1_busy1", {31'b0, busy_o}, 32'd1);
        tick();
        check("mis1_busy2", {31'b0, busy_o}, 32'd0);
        check("mis1_ready", {31'b0, pred_ready_o}, 32'd1);

        // Predicted taken, actually not: redirect pc+4; extra entry is cleared.
        push(32'h400, 1'b1, 32'h500);
        push(32'h700, 1'b0, 32'h0);
        resolve(1'b0, 32'h0, 1'b0, 0, 0, 0);
        check("drain_ready", {31'b0, pred_ready_o}, 32'd0);
        drive_pred(32'h900, 1'b0, 32'h0);
        res_valid_i = 1'b1;
        tick();
        idle_inputs();
        check("drain_ignore_bcnt", branch_cnt_o, m_bcnt);
        check("drain_ignore_ovf", {31'b0, ovf_o}, 32'd0);
        check("drain_busy", {31'b0, busy_o}, 32'd1);
        tick();
        check("drain_done", {31'b0, busy_o}, 32'd0);

        // Fill to DEPTH, then overflow.
        for (int i = 0; i < 4; i++) begin
            push(32'h1000 + 32'(i * 4), 1'b1, 32'h1040 + 32'(i * 4));
        end
        check("full_ready", {31'b0, pred_ready_o}, 32'd0);
        check("full_ovf0", {31'b0, ovf_o}, 32'd0);
        drive_pred(32'hdead, 1'b0, 32'h0);
        tick();
        idle_inputs();
        check("ovf_set", {31'b0, ovf_o}, 32'd1);

        // Push and correct pop together at full: accepted, still full.
        resolve(1'b1, 32'h1040, 1'b1, 32'h2000, 1'b0, 32'h0);
        check("pushpop_full", {31'b0, pred_ready_o}, 32'd0);
        // Next head must be the second fill entry.
        resolve(1'b0, 32'h0, 1'b0, 0, 0, 0);
        check("head_order_ready", {31'b0, pred_ready_o}, 32'd0);
        tick();
        tick();
        check("post_drain_ready", {31'b0, pred_ready_o}, 32'd1);

        // Reset in the first drain cycle.
        push(32'h3000, 1'b0, 32'h0);
        resolve(1'b1, 32'h10, 1'b0, 0, 0, 0);
        check("pre_rst_busy", {31'b0, busy_o}, 32'd1);
        rst = 1'b1;
        drive_pred(32'h3100, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        idle_inputs();
        mq.delete();
        m_bcnt  = 0;
        m_mcnt  = 0;
        m_redir = 0;
        check("rst_drain_busy", {31'b0, busy_o}, 32'd0);
        check("rst_drain_ready", {31'b0, pred_ready_o}, 32'd1);
        check("rst_drain_bcnt", branch_cnt_o, 32'd0);
        check("rst_drain_mcnt", mispred_cnt_o, 32'd0);
        check("rst_drain_flush", {31'b0, flush_o}, 32'd0);
        check("rst_drain_ovf", {31'b0, ovf_o}, 32'd0);
        check("rst_drain_unf", {31'b0, unf_o}, 32'd0);

        // Normal operation resumes after reset.
        push(32'h4000, 1'b0, 32'h0);
        resolve(1'b0, 32'h0, 1'b0, 0, 0, 0);
        check("post_rst_unf", {31'b0, unf_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
